exec_sequencer: RTL

- Multi-cycle control FSM for the single-issue core.
- Fetches one instruction at a time over a req/ack instruction-memory handshake and holds it in an instruction register.
- Decodes the opcode and enables exactly one execution unit (register-ALU or immediate-ALU) through its active-low enable.
- Strobes register-file writeback, advances the PC, and traps on an illegal opcode or a memory timeout.

---
 rtl/core_pkg.sv | 29 ++
 rtl/exec_sequencer_if.sv | 21 ++
 rtl/seq_timeout_counter.sv | 31 +++
 rtl/exec_sequencer.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// core_pkg: shared constants and types for the core sequencer and its helpers.
//   XLEN / REG_SELECT_LEN : datapath width and register-select field width
//   OPC_OP / OPC_OP_IMM   : opcodes that map onto the two execution units
//   seq_state_t           : sequencer FSM states
//   trap_cause_t          : trap cause encoding reported on trap_cause
package core_pkg;

  localparam int XLEN           = 32;
  localparam int REG_SELECT_LEN = 5;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } trap_cause_t;

endpackage

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: instruction-memory fetch port.
//   imem_req   : fetch request (master -> slave)
//   imem_addr  : fetch address (master -> slave)
//   imem_ack   : fetch data valid this cycle (slave -> master)
//   imem_rdata : fetched instruction word (slave -> master)
//
// Handshake: the master holds imem_req high with a stable imem_addr for as
// long as it waits for an instruction. A cycle with imem_req and imem_ack both
// high transfers imem_rdata; imem_ack is a single-cycle valid qualifier and is
// ignored whenever imem_req is low.
interface exec_sequencer_if #(
  parameter int XLEN = 32
);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [XLEN-1:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/seq_timeout_counter.sv
// seq_timeout_counter: wait-cycle counter for a memory handshake.
//   clk, rst : clock, asynchronous active-high reset
//   clear    : return count to zero (dominates incr)
//   incr     : count one more unanswered wait cycle
//   expired  : count has reached LIMIT-1, i.e. this is the last allowed cycle
module seq_timeout_counter #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic incr,
  output logic expired
);
  localparam int W = $clog2(LIMIT) + 1;

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)     count_d = '0;
    else if (incr) count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign expired = (count_q == W'(LIMIT - 1));
endmodule

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle control FSM for the single-issue core.
//   clk, rst          : clock, asynchronous active-high reset
//   imem              : instruction fetch port (exec_sequencer_if master)
//   instruction       : instruction register, broadcast to execution units
//   alu_reg_enable_n  : register-ALU enable, active low
//   alu_imm_enable_n  : immediate-ALU enable, active low
//   rf_we             : register-file write strobe
//   pc                : current program counter
//   retired           : retired-instruction count
//   trap, trap_cause  : sticky halt flag and its cause
//   dbg_state         : current FSM state
// Every output is decoded from state or registers only.
module exec_sequencer #(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = '0,
  parameter int              EXEC_CYCLES = 2,
  parameter int              MEM_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  exec_sequencer_if.master        imem,
  output logic [XLEN-1:0]         instruction,
  output logic                    alu_reg_enable_n,
  output logic                    alu_imm_enable_n,
  output logic                    rf_we,
  output logic [XLEN-1:0]         pc,
  output logic [XLEN-1:0]         retired,
  output logic                    trap,
  output logic [1:0]              trap_cause,
  output core_pkg::seq_state_t    dbg_state
);
  import core_pkg::*;

  localparam int EW = $clog2(EXEC_CYCLES) + 1;

  seq_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] retired_q, retired_d;
  trap_cause_t     cause_q, cause_d;
  logic [EW-1:0]   exec_cnt_q, exec_cnt_d;

  logic is_op, is_op_imm, rd_nonzero;
  logic tmo_clear, tmo_incr, tmo_expired;

  // Unit selection is decoded from the held instruction register, which
  // cannot change outside FETCH, so it stays stable through EXEC and WB.
  assign is_op      = (instr_q[6:0] == OPC_OP);
  assign is_op_imm  = (instr_q[6:0] == OPC_OP_IMM);
  assign rd_nonzero = (instr_q[7 +: REG_SELECT_LEN] != '0);

  // Wait count runs only while FETCH waits, and restarts on every exit.
  assign tmo_incr  = (state_q == ST_FETCH) && !imem.imem_ack;
  assign tmo_clear = (state_q != ST_FETCH) || (state_d != ST_FETCH);

  seq_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_fetch_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear),
    .incr    (tmo_incr),
    .expired (tmo_expired)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_BOOT;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      retired_q  <= '0;
      cause_q    <= CAUSE_NONE;
      exec_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      retired_q  <= retired_d;
      cause_q    <= cause_d;
      exec_cnt_q <= exec_cnt_d;
    end
  end

  // Next state
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    retired_d  = retired_q;
    cause_d    = cause_q;
    exec_cnt_d = exec_cnt_q;
    case (state_q)
      ST_BOOT:   state_d = ST_FETCH;
      ST_FETCH: begin
        // An ack in the expiring cycle still wins over the timeout.
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          state_d = ST_DECODE;
        end else if (tmo_expired) begin
          cause_d = CAUSE_TIMEOUT;
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        if (is_op || is_op_imm) begin
          exec_cnt_d = '0;
          state_d    = ST_EXEC;
        end else begin
          cause_d = CAUSE_ILLEGAL;
          state_d = ST_TRAP;
        end
      end
      ST_EXEC: begin
        if (exec_cnt_q == EW'(EXEC_CYCLES - 1)) state_d = ST_WB;
        else                                    exec_cnt_d = exec_cnt_q + 1'b1;
      end
      ST_WB: begin
        pc_d      = pc_q + XLEN'(4);
        retired_d = retired_q + XLEN'(1);
        state_d   = ST_FETCH;
      end
      ST_TRAP:   state_d = ST_TRAP;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Outputs
  always_comb begin
    imem.imem_req    = 1'b0;
    alu_reg_enable_n = 1'b1;
    alu_imm_enable_n = 1'b1;
    rf_we            = 1'b0;
    trap             = 1'b0;
    case (state_q)
      ST_FETCH: imem.imem_req = 1'b1;
      ST_EXEC: begin
        alu_reg_enable_n = !is_op;
        alu_imm_enable_n = !is_op_imm;
      end
      ST_WB: begin
        // Enable stays low so the unit keeps driving its result during the write.
        alu_reg_enable_n = !is_op;
        alu_imm_enable_n = !is_op_imm;
        rf_we            = rd_nonzero;
      end
      ST_TRAP:  trap = 1'b1;
      default:  ;
    endcase
  end

  assign imem.imem_addr = pc_q;
  assign instruction    = instr_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign trap_cause     = cause_q;
  assign dbg_state      = state_q;

  a_one_enable: assert property (@(posedge clk) disable iff (rst)
    (alu_reg_enable_n || alu_imm_enable_n));

endmodule
